// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// Control outputs are bundled in one packed struct so each pipeline situation is a single constant.
package pipe_ctrl_pkg;

    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF   = 16;
    localparam int REG_W       = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN       = 9'b11111_000_0;
    localparam ctrl_t CTRL_MEM_STALL = 9'b00001_001_0;
    localparam ctrl_t CTRL_BRANCH    = 9'b11111_110_0;
    localparam ctrl_t CTRL_LOAD_USE  = 9'b00111_010_0;
    localparam ctrl_t CTRL_HALT      = 9'b00000_000_1;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: an EX-stage load whose destination is read by the ID-stage instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wr,
    input  logic             ex_memrd,
    output logic             load_use
);

    logic [REG_W-1:0] src     [2];
    logic [1:0]       src_vld;
    logic [1:0]       src_hit;

    assign src[0]  = id_rs;
    assign src[1]  = id_rt;
    assign src_vld = {id_rt_vld, id_rs_vld};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_vld[gi] && (src[gi] == ex_rd);
        end
    endgenerate

    assign load_use = ex_memrd & ex_wr & (|src_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: memory-wait/halt FSM, timeout watchdog and stall counter.
// Priority of the combinational controls: HALT > memory stall > branch flush > load-use > run.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wr,
    input  logic             ex_memrd,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_done,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             load_use;
    logic             mem_stall;
    logic             timeout_hit;
    ctrl_t            ctrl;

    hazard_detect u_hazard (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rs_vld (id_rs_vld),
        .id_rt_vld (id_rt_vld),
        .ex_rd     (ex_rd),
        .ex_wr     (ex_wr),
        .ex_memrd  (ex_memrd),
        .load_use  (load_use)
    );

    // In MEM_WAIT the request is already in flight, so only mem_done matters.
    assign mem_stall   = ((state_q == ST_RUN) && mem_req && !mem_done) ||
                         ((state_q == ST_MEM_WAIT) && !mem_done);
    assign timeout_hit = (state_q == ST_MEM_WAIT) && !mem_done && (tcnt_q >= TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            tcnt_q      <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall)     state_d = ST_MEM_WAIT;
                else if (halt_mem) state_d = ST_HALT;
            end
            ST_MEM_WAIT: begin
                if (mem_done)         state_d = halt_mem ? ST_HALT : ST_RUN;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        if (state_q == ST_HALT) ctrl = CTRL_HALT;
        else if (mem_stall)     ctrl = CTRL_MEM_STALL;
        else if (br_taken)      ctrl = CTRL_BRANCH;
        else if (load_use)      ctrl = CTRL_LOAD_USE;
    end

    // The cycle that first issues the stalled request counts toward the timeout.
    always_comb begin
        tcnt_d = '0;
        if (state_q == ST_RUN && mem_stall)
            tcnt_d = TW'(1);
        else if (state_q == ST_MEM_WAIT && !mem_done && !timeout_hit)
            tcnt_d = tcnt_q + TW'(1);
    end

    always_comb begin
        mem_err_d   = mem_err_q | timeout_hit;
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && state_q != ST_HALT && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign idex_en      = ctrl.idex_en;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_en     = ctrl.memwb_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign halted       = ctrl.halted;
    assign mem_err      = mem_err_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl plus hand sequences for memory wait, timeout, halt and reset.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_rd;
    logic       id_rs_vld, id_rt_vld, ex_wr, ex_memrd, br_taken;
    logic       mem_req, mem_done, halt_mem;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_bubble, memwb_bubble, halted, mem_err;
    logic [2:0] stall_cnt;
    logic [4:0] en;
    logic [2:0] fb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_memrd(ex_memrd), .br_taken(br_taken),
        .mem_req(mem_req), .mem_done(mem_done), .halt_mem(halt_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fb = {ifid_flush, idex_bubble, memwb_bubble};

    typedef struct {
        logic [2:0] rs, rt;
        logic       rs_v, rt_v;
        logic [2:0] rd;
        logic       wr, memrd, br, mreq, mdone;
        logic [4:0] en;
        logic [2:0] fb;
        logic [2:0] cnt;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(int rs, int rt, int rsv, int rtv, int rd, int wr, int memrd,
                                int br, int mreq, int mdone, int e, int f, int cnt);
        vec_t v;
        v.rs = 3'(rs);     v.rt = 3'(rt);       v.rs_v = 1'(rsv); v.rt_v = 1'(rtv);
        v.rd = 3'(rd);     v.wr = 1'(wr);       v.memrd = 1'(memrd);
        v.br = 1'(br);     v.mreq = 1'(mreq);   v.mdone = 1'(mdone);
        v.en = 5'(e);      v.fb = 3'(f);        v.cnt = 3'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_rs_vld = 0; id_rt_vld = 0; ex_rd = 0;
        ex_wr = 0; ex_memrd = 0; br_taken = 0; mem_req = 0; mem_done = 0; halt_mem = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rs rt rsv rtv rd wr mrd br req done  en        fb      cnt
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0);
        vt[1]  = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 5'b00111, 3'b010, 1);
        vt[2]  = mk(3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 5'b11111, 3'b110, 1);
        vt[3]  = mk(1, 5, 0, 1, 5, 1, 1, 0, 0, 0, 5'b00111, 3'b010, 2);
        vt[4]  = mk(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 5'b11111, 3'b000, 2);
        vt[5]  = mk(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 5'b11111, 3'b000, 2);
        vt[6]  = mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 5'b11111, 3'b000, 2);
        vt[7]  = mk(2, 6, 1, 0, 6, 1, 1, 0, 0, 0, 5'b11111, 3'b000, 2);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11111, 3'b110, 2);
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 3'b000, 2);
        vt[10] = mk(4, 0, 1, 0, 4, 1, 1, 0, 1, 1, 5'b00111, 3'b010, 3);
        vt[11] = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 5'b00111, 3'b010, 4);
        vt[12] = mk(1, 7, 1, 1, 7, 1, 1, 0, 0, 0, 5'b00111, 3'b010, 5);
        vt[13] = mk(1, 7, 1, 1, 7, 1, 1, 0, 0, 0, 5'b00111, 3'b010, 6);
        vt[14] = mk(1, 7, 1, 1, 7, 1, 1, 0, 0, 0, 5'b00111, 3'b010, 7);
        vt[15] = mk(1, 7, 1, 1, 7, 1, 1, 0, 0, 0, 5'b00111, 3'b010, 7);
        vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 7);

        idle();
        rst = 1'b0;
        #2;
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_mem_err", 32'(mem_err), 0);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_en", 32'(en), 32'b11111);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            id_rs = vt[i].rs; id_rt = vt[i].rt; id_rs_vld = vt[i].rs_v; id_rt_vld = vt[i].rt_v;
            ex_rd = vt[i].rd; ex_wr = vt[i].wr; ex_memrd = vt[i].memrd; br_taken = vt[i].br;
            mem_req = vt[i].mreq; mem_done = vt[i].mdone; halt_mem = 1'b0;
            #1;
            chk($sformatf("vec%0d_en", i), 32'(en), 32'(vt[i].en));
            chk($sformatf("vec%0d_fb", i), 32'(fb), 32'(vt[i].fb));
            tick();
            chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(vt[i].cnt));
            $display("vec %0d: en=%b fb=%b stall_cnt=%0d", i, en, fb, stall_cnt);
        end

        // memory wait of three stalled cycles, released on the fourth
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_done = 1'b0;
            #1;
            chk($sformatf("memwait%0d_en", c), 32'(en), 32'b00001);
            chk($sformatf("memwait%0d_fb", c), 32'(fb), 32'b001);
        end
        @(negedge clk);
        mem_done = 1'b1;
        #1;
        chk("memwait_release_en", 32'(en), 32'b11111);
        chk("memwait_release_fb", 32'(fb), 32'b000);
        tick();
        chk("memwait_stall_cnt", 32'(stall_cnt), 3);
        chk("memwait_mem_err", 32'(mem_err), 0);
        $display("seq memwait: stall_cnt=%0d mem_err=%0d", stall_cnt, mem_err);

        // branch held during a memory wait is honoured on the release cycle
        do_reset();
        @(negedge clk);
        mem_req = 1'b1; mem_done = 1'b0; br_taken = 1'b1;
        #1;
        chk("brwait_stall_en", 32'(en), 32'b00001);
        @(negedge clk);
        mem_done = 1'b1;
        #1;
        chk("brwait_release_en", 32'(en), 32'b11111);
        chk("brwait_release_fb", 32'(fb), 32'b110);
        @(negedge clk);
        idle();
        #1;
        chk("brwait_back_to_run", 32'(en), 32'b11111);
        $display("seq brwait: en=%b fb=%b", en, fb);

        // timeout with TIMEOUT=4
        do_reset();
        @(negedge clk);
        mem_req = 1'b1; mem_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("timeout%0d_en", c), 32'(en), 32'b00001);
            chk($sformatf("timeout%0d_err", c), 32'(mem_err), 0);
            @(negedge clk);
        end
        #1;
        chk("timeout_mem_err", 32'(mem_err), 1);
        chk("timeout_halted", 32'(halted), 1);
        chk("timeout_en", 32'(en), 32'b00000);
        tick();
        chk("timeout_stall_cnt", 32'(stall_cnt), 4);
        chk("timeout_err_sticky", 32'(mem_err), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("timeout_reset_err", 32'(mem_err), 0);
        chk("timeout_reset_halted", 32'(halted), 0);
        $display("seq timeout: mem_err=%0d halted=%0d", mem_err, halted);
        @(negedge clk);
        rst = 1'b1;

        // HALT in MEM advances that cycle, then the core stays stopped
        do_reset();
        @(negedge clk);
        halt_mem = 1'b1;
        #1;
        chk("halt_cycle_en", 32'(en), 32'b11111);
        chk("halt_cycle_halted", 32'(halted), 0);
        @(negedge clk);
        halt_mem = 1'b0; br_taken = 1'b1; mem_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("halted%0d_flag", c), 32'(halted), 1);
            chk($sformatf("halted%0d_en", c), 32'(en), 32'b00000);
            chk($sformatf("halted%0d_fb", c), 32'(fb), 32'b000);
            @(negedge clk);
        end
        chk("halted_stall_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;
        #1;
        chk("halt_reset_halted", 32'(halted), 0);
        $display("seq halt: halted=%0d en=%b", halted, en);
        @(negedge clk);
        rst = 1'b1;

        // reset in the middle of a memory wait
        do_reset();
        @(negedge clk);
        mem_req = 1'b1; mem_done = 1'b0;
        tick();
        tick();
        chk("rstwait_pre_cnt", 32'(stall_cnt), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("rstwait_cnt", 32'(stall_cnt), 0);
        chk("rstwait_err", 32'(mem_err), 0);
        chk("rstwait_halted", 32'(halted), 0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        chk("rstwait_run_en", 32'(en), 32'b11111);
        tick();
        chk("rstwait_run_cnt", 32'(stall_cnt), 0);
        $display("seq rstwait: en=%b stall_cnt=%0d", en, stall_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
